// File: rtl/rename_pkg.sv
// Shared rename-stage definitions: default register-file sizes, derived widths and the tag type.
package rename_pkg;

  localparam int ARCHFILE_SIZE_DEF = 32;
  localparam int PHYSFILE_SIZE_DEF = 256;
  localparam int TAG_W             = $clog2(PHYSFILE_SIZE_DEF);
  localparam int PTR_W             = TAG_W + 1;

  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [PTR_W-1:0] ptr_t;

endpackage

// File: rtl/freelist_ram.sv
// Free-tag storage: one synchronous write port, one asynchronous read port,
// contents loaded with the initial free tags while reset is asserted.
module freelist_ram #(
  parameter int DEPTH      = 256,
  parameter int WIDTH      = 8,
  parameter int INIT_COUNT = 224,
  parameter int INIT_BASE  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the storage is reset on purpose -- the list must come up holding tags
  // ARCHFILE_SIZE.. so it cannot be a plain RAM macro without an init sequencer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= (i < INIT_COUNT) ? WIDTH'(INIT_BASE + i) : '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/phys_freelist.sv
// Physical-register free list with speculative and committed heads.
// Optional stall statistic enabled by defining FREELIST_STATS_EN.
module phys_freelist
  import rename_pkg::*;
#(
  parameter int ARCHFILE_SIZE = ARCHFILE_SIZE_DEF,
  parameter int PHYSFILE_SIZE = PHYSFILE_SIZE_DEF
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             alloc_req,
  output logic                             alloc_gnt,
  output logic [$clog2(PHYSFILE_SIZE)-1:0] alloc_phys,
  input  logic                             free_valid,
  input  logic [$clog2(PHYSFILE_SIZE)-1:0] free_phys,
  input  logic                             commit_alloc,
  input  logic                             rollback,
  output logic [$clog2(PHYSFILE_SIZE):0]   free_count,
  output logic                             overflow_err,
  output logic [31:0]                      alloc_stall_cnt
);

  localparam int TW = $clog2(PHYSFILE_SIZE);
  localparam int PW = TW + 1;
  localparam logic [PW-1:0] INIT_TAIL = PW'(PHYSFILE_SIZE - ARCHFILE_SIZE);
  localparam logic [PW-1:0] FULL_CNT  = PW'(PHYSFILE_SIZE);

  logic [PW-1:0] spec_head, commit_head, tail;
  logic          empty, full, wr_en;

  // Pointers carry a wrap bit, so full (distance == depth) differs from empty.
  assign free_count = tail - spec_head;
  assign empty      = (free_count == '0);
  assign full       = ((tail - commit_head) == FULL_CNT);
  assign alloc_gnt  = alloc_req & ~empty & ~rollback;
  assign wr_en      = free_valid & ~full;

  freelist_ram #(
    .DEPTH      (PHYSFILE_SIZE),
    .WIDTH      (TW),
    .INIT_COUNT (PHYSFILE_SIZE - ARCHFILE_SIZE),
    .INIT_BASE  (ARCHFILE_SIZE)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .waddr (tail[TW-1:0]),
    .wdata (free_phys),
    .raddr (spec_head[TW-1:0]),
    .rdata (alloc_phys)
  );

  // NOTE: all state uses non-blocking assignments so every pointer update in a
  // cycle sees the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spec_head    <= '0;
      commit_head  <= '0;
      tail         <= INIT_TAIL;
      overflow_err <= 1'b0;
    end else begin
      commit_head <= commit_head + PW'(commit_alloc);
      // Rollback restores the speculative head to the committed one, including this cycle's commit.
      if (rollback)
        spec_head <= commit_head + PW'(commit_alloc);
      else if (alloc_gnt)
        spec_head <= spec_head + 1'b1;
      if (wr_en)
        tail <= tail + 1'b1;
      if (free_valid && full)
        overflow_err <= 1'b1;
    end
  end

`ifdef FREELIST_STATS_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (alloc_req && !alloc_gnt && stall_cnt != '1)
      stall_cnt <= stall_cnt + 1'b1;
  end

  assign alloc_stall_cnt = stall_cnt;
`else
  assign alloc_stall_cnt = '0;
`endif

endmodule

// File: doc/phys_freelist.md
PHYS_FREELIST -- requirements
Module: phys_freelist

Interface
REQ-001 SHALL have parameter ARCHFILE_SIZE, default 32, number of architectural registers.
REQ-002 SHALL have parameter PHYSFILE_SIZE, default 256, number of physical registers; power of two and greater than ARCHFILE_SIZE.
REQ-003 SHALL have port clk, input, 1, single clock; all state rising-edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port alloc_req, input, 1, rename requests one physical tag.
REQ-006 SHALL have port alloc_gnt, output, 1, tag granted this cycle.
REQ-007 SHALL have port alloc_phys, output, $clog2(PHYSFILE_SIZE), granted tag; valid when alloc_gnt=1.
REQ-008 SHALL have port free_valid, input, 1, ROB commit returns a stale tag.
REQ-009 SHALL have port free_phys, input, $clog2(PHYSFILE_SIZE), stale tag (committed arch_wr_oldphys).
REQ-010 SHALL have port commit_alloc, input, 1, ROB committed a uop that allocated a tag.
REQ-011 SHALL have port rollback, input, 1, flush all speculative allocations.
REQ-012 SHALL have port free_count, output, $clog2(PHYSFILE_SIZE)+1, tags available to speculative allocation.
REQ-013 SHALL have port overflow_err, output, 1, sticky: free pushed into full list.
REQ-014 SHALL have port alloc_stall_cnt, output, 32, stall statistic (see Configuration).

Function
REQ-015 SHALL store free tags in a PHYSFILE_SIZE-entry circular buffer with pointers spec_head, commit_head, tail, each $clog2(PHYSFILE_SIZE)+1 bits; MSB is the wrap bit.
REQ-016 SHALL compute free_count = tail - spec_head, with empty when free_count==0.
REQ-017 SHALL drive alloc_gnt = alloc_req & !empty & !rollback, combinationally.
REQ-018 SHALL drive alloc_phys = entry[spec_head], combinationally, in the same cycle as alloc_gnt.
REQ-019 SHALL advance spec_head by 1 at the edge ending a cycle with alloc_gnt=1.
REQ-020 SHALL, on free_valid, write free_phys at tail and advance tail by 1; the tag becomes allocatable the next cycle; no same-cycle bypass.
REQ-021 SHALL, on commit_alloc, advance commit_head by 1.
REQ-022 SHALL, on rollback, load spec_head with commit_head after this cycle's commit_alloc increment is applied.
REQ-023 SHALL honour free_valid and commit_alloc in a rollback cycle, because both are non-speculative.
REQ-024 SHALL handle alloc and free in the same cycle independently; free_count is unchanged.
REQ-025 SHALL, when the buffer is full (tail - commit_head == PHYSFILE_SIZE) and free_valid=1, drop the write, hold tail and set overflow_err until reset.
REQ-026 SHALL make all pointer arithmetic wrap modulo 2*PHYSFILE_SIZE.

Reset
REQ-027 SHALL, while rst=1 and asynchronously, fill entry[i] = ARCHFILE_SIZE+i for i < PHYSFILE_SIZE-ARCHFILE_SIZE.
REQ-028 SHALL, under the same reset, set spec_head=commit_head=0, tail=PHYSFILE_SIZE-ARCHFILE_SIZE and clear overflow_err and alloc_stall_cnt.
REQ-029 SHALL produce reset outputs alloc_gnt=0, free_count=PHYSFILE_SIZE-ARCHFILE_SIZE (224 at defaults), alloc_phys=ARCHFILE_SIZE (32), overflow_err=0.
REQ-030 SHALL abort any in-progress allocation, free or rollback when reset is asserted mid-operation; no partial pointer update survives.

Configuration
REQ-031 SHALL, with FREELIST_STATS_EN defined, increment alloc_stall_cnt each cycle alloc_req=1 and alloc_gnt=0, saturating at 2^32-1.
REQ-032 SHALL, without FREELIST_STATS_EN, tie alloc_stall_cnt to 0 and compile no counter logic.

Structure
REQ-033 SHALL place ARCHFILE_SIZE/PHYSFILE_SIZE-derived widths and the tag typedef in shared package rename_pkg.
REQ-034 SHALL implement storage as sub-module freelist_ram (one sync write port, one async read port, reset-initialised contents).

Verification
REQ-035 SHALL check reset then alloc_req for 3 cycles -> alloc_phys 32, 33, 34 granted; free_count 221.
REQ-036 SHALL check 224 grants then alloc_req -> alloc_gnt=0, free_count=0; with FREELIST_STATS_EN, 5 stalled cycles give alloc_stall_cnt=5.
REQ-037 SHALL check empty list plus free_valid with free_phys=7 and alloc_req in the same cycle -> no grant; next cycle alloc_phys=7 granted.
REQ-038 SHALL check 4 allocs, commit_alloc x1, then rollback together with alloc_req -> alloc_gnt=0 that cycle; next grant is 33; free_count=223.
REQ-039 SHALL check rollback together with commit_alloc and free_valid (phys 5) -> spec_head = old commit_head+1 and tag 5 appended at tail.
REQ-040 SHALL check free_valid while 256 tags are held -> write dropped, tail unchanged, overflow_err=1 until rst.
